// File: rtl/ins_fetch.sv
// ins_fetch: instruction fetch/issue stage feeding the cpu top.
// A host fills a small program buffer over a valid/ready load port; after
// start, the word at the cpu's pc is driven on ins_out with a one-cycle
// cpu_set strobe, then the stage waits for pc to move before issuing again.
// Ports: clk, rst (sync, active-low); load_valid/load_ready/load_data/
// load_last (host load); start, pc (control/cpu pc); ins_out, cpu_set
// (to cpu); busy, done, load_err, timeout (status).
// Optional: define INS_FETCH_TIMEOUT_EN to enable the WAIT-state watchdog.
module ins_fetch #(
  parameter int INS_WIDTH = 32,
  parameter int DEPTH     = 16,
  parameter int PC_WIDTH  = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [INS_WIDTH-1:0] load_data,
  input  logic                 load_last,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic [INS_WIDTH-1:0] ins_out,
  output logic                 cpu_set,
  output logic                 busy,
  output logic                 done,
  output logic                 load_err,
  output logic                 timeout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 256 || TIMEOUT < 2) begin : g_bad_param
    $error("ins_fetch: unsupported DEPTH/TIMEOUT");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  closed_q, closed_d;
  logic [PC_WIDTH-1:0]   last_pc_q, last_pc_d;
  logic [INS_WIDTH-1:0]  ins_q, ins_d;
  logic                  cpu_set_q, cpu_set_d;
  logic                  load_err_q, load_err_d;
  logic [INS_WIDTH-1:0]  mem_q [DEPTH];

  logic                  load_fire;
  logic                  pc_in_prog;
  logic [AW-1:0]         rd_addr;

`ifdef INS_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                  timeout_q, timeout_d;
`endif

  assign load_ready = (state_q == S_IDLE) && !closed_q;
  assign load_fire  = load_valid && load_ready;
  // Compare at a common width so any PC_WIDTH works against count.
  assign pc_in_prog = 32'(pc) < 32'(count_q);
  assign rd_addr    = AW'(pc);

  assign ins_out  = ins_q;
  assign cpu_set  = cpu_set_q;
  assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done     = (state_q == S_DONE);
  assign load_err = load_err_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    closed_d   = closed_q;
    last_pc_d  = last_pc_q;
    ins_d      = ins_q;
    cpu_set_d  = 1'b0;
    load_err_d = load_err_q;
`ifdef INS_FETCH_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    timeout_d  = timeout_q;
`endif
    if (load_valid && closed_q) begin
      load_err_d = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (load_fire) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (load_last || wr_ptr_q == AW'(DEPTH - 1)) begin
            closed_d = 1'b1;
            count_d  = CW'(wr_ptr_q) + CW'(1);
          end
        end
        // Uses the registered closed flag: a start that arrives with the
        // closing word waits one cycle.
        if (start && closed_q) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (pc_in_prog) begin
          ins_d     = mem_q[rd_addr];
          cpu_set_d = 1'b1;
          last_pc_d = pc;
          state_d   = S_WAIT;
`ifdef INS_FETCH_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (pc != last_pc_q) begin
          state_d = pc_in_prog ? S_ISSUE : S_DONE;
        end else begin
`ifdef INS_FETCH_TIMEOUT_EN
          // Stalled cpu: re-strobe the held instruction.
          if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
            tmo_cnt_d = '0;
            cpu_set_d = 1'b1;
            timeout_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
`endif
        end
      end
      S_DONE: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      closed_q   <= 1'b0;
      last_pc_q  <= '0;
      ins_q      <= '0;
      cpu_set_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      closed_q   <= closed_d;
      last_pc_q  <= last_pc_d;
      ins_q      <= ins_d;
      cpu_set_q  <= cpu_set_d;
      load_err_q <= load_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && load_fire) begin
      mem_q[wr_ptr_q] <= load_data;
    end
  end

`ifdef INS_FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// tb_ins_fetch: directed table plus hand sequences for ins_fetch.
// Inputs change 1ns after each rising edge; outputs sampled there too.
module tb_ins_fetch;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        start;
  logic [7:0]  pc;
  logic [31:0] ins_out;
  logic        cpu_set;
  logic        busy;
  logic        done;
  logic        load_err;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  ins_fetch #(
    .INS_WIDTH(32),
    .DEPTH(16),
    .PC_WIDTH(8),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data(load_data),
    .load_last(load_last),
    .start(start),
    .pc(pc),
    .ins_out(ins_out),
    .cpu_set(cpu_set),
    .busy(busy),
    .done(done),
    .load_err(load_err),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog sim time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic        lv;
    logic [31:0] d;
    logic        last;
    logic        st;
    logic [7:0]  pc;
    logic        e_lr;
    logic        e_cs;
    logic [31:0] e_ins;
    logic        e_busy;
    logic        e_done;
    logic        e_lerr;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(
    input logic r, input logic lv, input logic [31:0] d,
    input logic last, input logic st, input logic [7:0] p,
    input logic lr, input logic cs, input logic [31:0] ins,
    input logic b, input logic dn, input logic le);
    vec_t v;
    v.rst = r;   v.lv = lv;     v.d = d;
    v.last = last; v.st = st;   v.pc = p;
    v.e_lr = lr; v.e_cs = cs;   v.e_ins = ins;
    v.e_busy = b; v.e_done = dn; v.e_lerr = le;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    load_valid = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    start = 1'b0;
    pc = '0;
    tick();
    rst = 1'b1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data = d;
    load_last = last;
    tick();
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask

  localparam logic [31:0] W1 = 32'h1111_1111;
  localparam logic [31:0] W2 = 32'h2222_2222;
  localparam logic [31:0] W3 = 32'h3333_3333;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  initial begin
    int pulses;
    int extra;
    int b2b;
    logic prev;

    rst = 1'b0;
    load_valid = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    start = 1'b0;
    pc = '0;

    //            rst lv d    last st pc  lr cs ins b  dn le
    tbl[0]  = mk(0, 0, 0,   0, 0, 0,  1, 0, 0,  0, 0, 0);
    tbl[1]  = mk(1, 1, W1,  0, 0, 0,  1, 0, 0,  0, 0, 0);
    tbl[2]  = mk(1, 1, W2,  0, 0, 0,  1, 0, 0,  0, 0, 0);
    tbl[3]  = mk(1, 1, W3,  1, 0, 0,  0, 0, 0,  0, 0, 0);
    tbl[4]  = mk(1, 0, 0,   0, 1, 0,  0, 0, 0,  1, 0, 0);
    tbl[5]  = mk(1, 0, 0,   0, 1, 0,  0, 1, W1, 1, 0, 0);
    tbl[6]  = mk(1, 0, 0,   0, 0, 0,  0, 0, W1, 1, 0, 0);
    tbl[7]  = mk(1, 0, 0,   0, 0, 1,  0, 0, W1, 1, 0, 0);
    tbl[8]  = mk(1, 0, 0,   0, 0, 1,  0, 1, W2, 1, 0, 0);
    tbl[9]  = mk(1, 0, 0,   0, 0, 2,  0, 0, W2, 1, 0, 0);
    tbl[10] = mk(1, 0, 0,   0, 0, 2,  0, 1, W3, 1, 0, 0);
    tbl[11] = mk(1, 0, 0,   0, 0, 3,  0, 0, W3, 0, 1, 0);
    tbl[12] = mk(1, 0, 0,   0, 0, 3,  0, 0, W3, 0, 1, 0);
    tbl[13] = mk(1, 0, 0,   0, 1, 0,  0, 0, W3, 0, 1, 0);
    tbl[14] = mk(1, 1, BAD, 0, 0, 0,  0, 0, W3, 0, 1, 1);
    tbl[15] = mk(0, 0, 0,   0, 0, 0,  1, 0, 0,  0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst;
      load_valid = tbl[i].lv;
      load_data = tbl[i].d;
      load_last = tbl[i].last;
      start = tbl[i].st;
      pc = tbl[i].pc;
      tick();
      chk($sformatf("v%0d_load_ready", i), load_ready, tbl[i].e_lr);
      chk($sformatf("v%0d_cpu_set", i), cpu_set, tbl[i].e_cs);
      chk($sformatf("v%0d_ins_out", i), ins_out, tbl[i].e_ins);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("v%0d_load_err", i), load_err, tbl[i].e_lerr);
      chk($sformatf("v%0d_timeout", i), timeout, 0);
    end

    // Reset taken while in WAIT.
    do_reset();
    load_word(32'h1234_5678, 1'b1);
    start = 1'b1;
    tick();
    tick();
    chk("rstwait_pulse", cpu_set, 1);
    tick();
    chk("rstwait_busy_pre", busy, 1);
    rst = 1'b0;
    tick();
    chk("rstwait_load_ready", load_ready, 1);
    chk("rstwait_cpu_set", cpu_set, 0);
    chk("rstwait_busy", busy, 0);
    chk("rstwait_done", done, 0);
    chk("rstwait_ins_out", ins_out, 0);
    rst = 1'b1;
    start = 1'b0;

    // Start before any load is ignored; issue follows the close.
    do_reset();
    start = 1'b1;
    repeat (3) begin
      tick();
      chk("early_start_busy", busy, 0);
    end
    load_word(32'hA5A5_A5A5, 1'b1);
    chk("close_same_cycle_busy", busy, 0);
    tick();
    chk("issue_after_close_busy", busy, 1);
    tick();
    chk("late_issue_cpu_set", cpu_set, 1);
    chk("late_issue_ins", ins_out, 32'hA5A5_A5A5);
    pc = 8'd1;
    tick();
    chk("one_word_done", done, 1);

    // pc beyond program at first issue.
    do_reset();
    load_word(W1, 1'b0);
    load_word(W2, 1'b0);
    load_word(W3, 1'b1);
    pc = 8'd5;
    start = 1'b1;
    tick();
    tick();
    chk("pc5_cpu_set", cpu_set, 0);
    chk("pc5_done", done, 1);
    chk("pc5_busy", busy, 0);
    chk("pc5_ins_out", ins_out, 0);

    // Full buffer, overflow load, run all 16 entries.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      load_word(32'hA000_0000 + 32'(i), 1'b0);
      if (i == 14) chk("full_ready_before", load_ready, 1);
    end
    chk("full_ready_after", load_ready, 0);
    load_word(BAD, 1'b0);
    chk("overflow_load_err", load_err, 1);
    start = 1'b1;
    tick();
    pulses = 0;
    prev = 1'b0;
    b2b = 0;
    for (int p = 0; p < 16; p++) begin
      pc = 8'(p);
      repeat (3) begin
        tick();
        if (prev && cpu_set) b2b++;
        prev = cpu_set;
        if (cpu_set) begin
          pulses++;
          chk($sformatf("full_ins_%0d", p), ins_out,
              32'hA000_0000 + 32'(p));
        end
      end
    end
    chk("full_pulses", 32'(pulses), 16);
    chk("full_no_b2b", 32'(b2b), 0);
    pc = 8'd16;
    tick();
    chk("full_done", done, 1);

    // Stalled pc: watchdog behaviour.
    do_reset();
    load_word(32'hC0C0_C0C0, 1'b0);
    load_word(32'hC1C1_C1C1, 1'b1);
    pc = 8'd0;
    start = 1'b1;
    tick();
    tick();
    chk("stall_first_pulse", cpu_set, 1);
    chk("stall_first_ins", ins_out, 32'hC0C0_C0C0);
    extra = 0;
    b2b = 0;
    prev = 1'b1;
    repeat (200) begin
      tick();
      if (prev && cpu_set) b2b++;
      prev = cpu_set;
      if (cpu_set) extra++;
    end
`ifdef INS_FETCH_TIMEOUT_EN
    chk("stall_extra_pulses", 32'(extra), 3);
    chk("stall_timeout", timeout, 1);
`else
    chk("stall_extra_pulses", 32'(extra), 0);
    chk("stall_timeout", timeout, 0);
`endif
    chk("stall_no_b2b", 32'(b2b), 0);
    chk("stall_ins_held", ins_out, 32'hC0C0_C0C0);
    chk("stall_busy", busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_fetch.md
Name: ins_fetch

Overview:
Instruction fetch/issue stage directly upstream of the cpu top. Holds a small program buffer filled by a host over a valid/ready load port. After start, it presents the instruction at the cpu's current pc on ins_out and pulses cpu_set once per instruction. It then waits for pc to move before issuing the next instruction.

Parameters:
INS_WIDTH, 32, instruction word width (matches cpu ins_in)
DEPTH, 16, program buffer entries (power of 2, max 256)
PC_WIDTH, 8, width of cpu pc
TIMEOUT, 64, WAIT-state watchdog limit in cycles (used only with optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets)
load_valid  in  1  host load word valid
load_ready  out  1  buffer accepts a load word
load_data  in  INS_WIDTH  instruction word to store
load_last  in  1  marks final program word, qualified by load_valid&load_ready
start  in  1  level, begin issuing
pc  in  PC_WIDTH  program counter from cpu
ins_out  out  INS_WIDTH  instruction to cpu ins_in, registered
cpu_set  out  1  one-cycle strobe to cpu cpu_set, registered
busy  out  1  high in ISSUE/WAIT
done  out  1  high in DONE
load_err  out  1  sticky: load attempted after buffer closed
timeout  out  1  sticky watchdog flag (optional feature; else 0)

Behaviour:
- Reset values: load_ready=1, ins_out=0, cpu_set=0, busy=0, done=0, load_err=0, timeout=0.
- Reset also clears: state=IDLE, wr_ptr=0, count=0, closed=0. Buffer contents are not cleared.
- Reset mid-operation aborts any state the same way, at the next edge with rst==0.
- States: IDLE, ISSUE, WAIT, DONE.
- Load (IDLE only), load_ready = !closed.
  - On load_valid&load_ready: mem[wr_ptr]<=load_data, wr_ptr++.
  - If load_last is set, or wr_ptr==DEPTH-1: closed<=1 and count<=wr_ptr+1.
  - load_valid while closed (in any state) sets load_err; nothing is written.
  - load_ready=0 outside IDLE.
- IDLE -> ISSUE: start==1 && closed==1. Start with no closed program is ignored.
- ISSUE, one cycle, with p = pc sampled this cycle:
  - If p<count: ins_out<=mem[p], cpu_set<=1, last_pc<=p, state->WAIT.
  - Else: state->DONE and cpu_set stays 0.
- WAIT:
  - cpu_set auto-clears after one cycle.
  - When pc!=last_pc, go to ISSUE next cycle.
  - If pc>=count in that same cycle, go to DONE instead.
  - start deassertion in WAIT/ISSUE has no effect.
- DONE is terminal until reset: done=1, busy=0.
- Latency:
  - start high at edge N (state IDLE) -> ISSUE after N -> cpu_set/ins_out valid after edge N+1.
  - pc change seen at edge M -> next cpu_set valid after edge M+1.
- Simultaneous load_valid and start in IDLE with program still open: the load is accepted; start waits until closed.
- cpu_set is never high for two consecutive cycles.

Optional Feature:
Macro INS_FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and resets on entry to WAIT.
  - If pc stays ==last_pc for TIMEOUT cycles: set timeout (sticky), re-issue the same instruction (cpu_set pulse, ins_out unchanged), restart the counter.
- Not defined:
  - No counter exists, timeout is tied to 0, and WAIT waits indefinitely.

Test Plan:
- Reset with all inputs 0 -> load_ready=1, cpu_set=0, busy=0, done=0, ins_out=0. Hold rst=0 in WAIT -> same values next edge, load_ready=1.
- Load 3 words 0x11111111, 0x22222222, 0x33333333 (last on 3rd), start=1, pc=0 -> cpu_set pulse with ins_out=0x11111111 two edges after start. Step pc 1, 2 -> ins_out 0x22222222, 0x33333333. pc=3 -> done=1 and no further cpu_set.
- Load 16 words without load_last -> load_ready=0 after 16th. Extra load_valid -> load_err=1 and mem unchanged. Run to pc=15 -> 16 cpu_set pulses.
- Hold pc=0 after first issue for 200 cycles:
  - macro off: single pulse, timeout=0.
  - macro on (TIMEOUT=64): re-pulse at 64-cycle intervals, timeout=1.
- start=1 before any load -> stays IDLE, busy=0. Then load 1 word with last -> issue begins the cycle after closed.
- Start with pc=5 and count=3 -> DONE without cpu_set.
